mem_router: RTL and testbench

MEM_ROUTER -- requirements
Module: mem_router

---
 rtl/mem_router.sv | 181 ++++++++++++++++++
 tb/tb_mem_router.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// Address-decoding router: one master request is steered to one of N_REGIONS
// slave ports, with a per-access timeout and a single-cycle response strobe.
module mem_router #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_REGIONS  = 2,
    parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h0010_0000, 32'h0000_0000},
    parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_SIZE = {32'h0010_0000, 32'h0010_0000},
    parameter int TIMEOUT    = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [N_REGIONS-1:0]            s_sel,
    output logic                            s_we,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic [N_REGIONS-1:0]            s_ack,
    input  logic [N_REGIONS*DATA_WIDTH-1:0] s_rdata
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [N_REGIONS-1:0]    r_sel, w_sel_nxt;
    logic                    r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic                    r_err, w_err_nxt;
    logic                    r_rsp_valid;
    logic                    r_ready;

    logic [N_REGIONS-1:0]    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_hit_any;
    logic [N_REGIONS-1:0]    w_sel_dec;
    logic [ADDR_WIDTH-1:0]   w_off;
    logic                    w_ack;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;

    // Region hit test; the end address carries one extra bit so a region touching the top decodes.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            w_hit[i] = ({1'b0, req_addr} >= {1'b0, REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]}) &&
                       ({1'b0, req_addr} < ({1'b0, REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]} +
                                            {1'b0, REGION_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]}));
        end
    end

    // Lowest-index priority among overlapping hits, plus region-relative offset.
    always_comb begin
        w_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            w_idx = w_hit[i] ? IDX_W'(i) : w_idx;
        end
        w_hit_any = |w_hit;
        w_sel_dec = w_hit_any ? (N_REGIONS'(1) << w_idx) : '0;
        w_off     = w_hit_any ? (req_addr - REGION_BASE[w_idx*ADDR_WIDTH +: ADDR_WIDTH]) : req_addr;
    end

    // Ack and read data of the selected slave only.
    always_comb begin
        w_ack       = |(s_ack & r_sel);
        w_sel_rdata = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            w_sel_rdata = w_sel_rdata | ({DATA_WIDTH{r_sel[i]}} & s_rdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Next-state and next-register logic of the transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_we_nxt    = req_we;
                    w_addr_nxt  = w_off;
                    w_wdata_nxt = req_wdata;
                    w_cnt_nxt   = '0;
                    if (w_hit_any) begin
                        w_sel_nxt   = w_sel_dec;
                        w_state_nxt = S_ACCESS;
                    end else begin
                        w_sel_nxt   = '0;
                        w_rdata_nxt = '0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (w_ack) begin
                    w_rdata_nxt = r_we ? '0 : w_sel_rdata;
                    w_err_nxt   = 1'b0;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_sel_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_ready     <= (w_state_nxt == S_IDLE);
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign s_sel     = r_sel;
    assign s_we      = r_we;
    assign s_addr    = r_addr;
    assign s_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed scenarios plus randomized
// transactions compared against an address-map / latency reference model.
module tb_mem_router;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 15;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [NR-1:0] s_sel;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [NR-1:0] s_ack;
    logic [NR*DW-1:0] s_rdata;

    int n_tests;
    int n_fail;

    mem_router #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_REGIONS  (NR),
        .REGION_BASE({32'h0010_0000, 32'h0000_0000}),
        .REGION_SIZE({32'h0010_0000, 32'h0010_0000}),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_ack     (s_ack),
        .s_rdata   (s_rdata)
    );

    always #5 clk = ~clk;

    // Memory map as plain arithmetic: first matching region wins, -1 if none.
    function automatic int model_region(input logic [31:0] a);
        longint base [2];
        longint size [2];
        longint la;
        base[0] = 64'h0000_0000; size[0] = 64'h0010_0000;
        base[1] = 64'h0010_0000; size[1] = 64'h0010_0000;
        la = longint'(a);
        for (int i = 0; i < 2; i++)
            if (la >= base[i] && la < base[i] + size[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_base(input int r);
        return (r == 1) ? 32'h0010_0000 : 32'h0000_0000;
    endfunction

    // One transaction, entered and left at a negedge. ack_at = ACCESS cycle of the ack (0 = never).
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] rdata, input bit stray, input bit hold);
        int r;
        int c;
        bit done;
        logic [31:0] exp_rd;
        logic exp_err;
        logic [1:0] exp_sel;
        r = model_region(addr);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_before addr=%h got %b want 1", addr, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        if (hold && r >= 0) begin
            req_addr = 32'h0030_0000; req_we = ~we; req_wdata = ~wdata;
        end else begin
            req_valid = 1'b0;
        end
        exp_rd = 32'h0; exp_err = 1'b1;
        if (r >= 0) begin
            exp_sel = 2'b01 << r;
            c = 1; done = 1'b0;
            while (!done) begin
                n_tests += 6;
                if (s_sel !== exp_sel) begin n_fail++; $display("FAIL acc_sel c=%0d got %b want %b", c, s_sel, exp_sel); end
                if (s_addr !== addr - model_base(r)) begin n_fail++; $display("FAIL acc_addr c=%0d got %h want %h", c, s_addr, addr - model_base(r)); end
                if (s_we !== we) begin n_fail++; $display("FAIL acc_we c=%0d got %b want %b", c, s_we, we); end
                if (s_wdata !== wdata) begin n_fail++; $display("FAIL acc_wdata c=%0d got %h want %h", c, s_wdata, wdata); end
                if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL acc_rspv c=%0d got %b want 0", c, rsp_valid); end
                if (req_ready !== 1'b0) begin n_fail++; $display("FAIL acc_ready c=%0d got %b want 0", c, req_ready); end
                s_rdata = {~rdata, ~rdata};
                s_rdata[r*32 +: 32] = rdata;
                s_ack = 2'b00;
                if (c == ack_at) s_ack[r] = 1'b1;
                if (stray) s_ack[1-r] = 1'b1;
                @(negedge clk);
                s_ack = 2'b00;
                if (c == ack_at) begin
                    exp_rd = we ? 32'h0 : rdata; exp_err = 1'b0; done = 1'b1;
                end else if (c == TO) begin
                    done = 1'b1;
                end
                c++;
            end
        end
        n_tests += 4;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_valid addr=%h got %b want 1", addr, rsp_valid); end
        if (rsp_err !== exp_err) begin n_fail++; $display("FAIL rsp_err addr=%h got %b want %b", addr, rsp_err, exp_err); end
        if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL rsp_rdata addr=%h got %h want %h", addr, rsp_rdata, exp_rd); end
        if (s_sel !== 2'b00) begin n_fail++; $display("FAIL rsp_sel addr=%h got %b want 00", addr, s_sel); end
        req_valid = 1'b0;
        @(negedge clk);
        n_tests += 4;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_once addr=%h got %b want 0", addr, rsp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after addr=%h got %b want 1", addr, req_ready); end
        if (rsp_err !== exp_err) begin n_fail++; $display("FAIL err_hold addr=%h got %b want %b", addr, rsp_err, exp_err); end
        if (rsp_rdata !== exp_rd) begin n_fail++; $display("FAIL rdata_hold addr=%h got %h want %h", addr, rsp_rdata, exp_rd); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests += 7;
        if (s_sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel got %b want 00", s_sel); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rspv got %b want 0", rsp_valid); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", rsp_err); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
        if (s_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", s_we); end
        if (s_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", s_addr); end
        if (s_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", s_wdata); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_read_slave0();
        run_txn(1'b0, 32'h0000_0010, 32'h0, 2, 32'hCAFE_0001, 1'b0, 1'b0);
    endtask

    task automatic test_write_slave1();
        run_txn(1'b1, 32'h0010_0004, 32'h0000_0055, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_unmapped();
        run_txn(1'b0, 32'h0030_0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b1, 32'h0020_0000, 32'h1234, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h0010_0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0010_0000, 32'h0, TO, 32'h1357_9BDF, 1'b0, 1'b0);
        run_txn(1'b0, 32'h000F_FFFC, 32'h0, TO, 32'h2468_ACE0, 1'b1, 1'b0);
    endtask

    task automatic test_stray_and_hold();
        run_txn(1'b0, 32'h001F_FFFF, 32'h0, 3, 32'hA5A5_0F0F, 1'b1, 1'b1);
        run_txn(1'b1, 32'h0000_0000, 32'h7777_0000, 0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0: a = 32'h0000_0000 + ($urandom & 32'h000F_FFFF);
                1: a = 32'h0010_0000 + ($urandom & 32'h000F_FFFF);
                2: a = 32'h0020_0000 + ($urandom & 32'h00FF_FFFF);
                default: a = $urandom;
            endcase
            run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, TO), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0010_0040; req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        s_ack = 2'b01; s_rdata = {32'h1111_1111, 32'h2222_2222};
        @(negedge clk);
        s_ack = 2'b00;
        n_tests += 2;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rspv got %b want 0", rsp_valid); end
        if (s_sel !== 2'b10) begin n_fail++; $display("FAIL stray_sel got %b want 10", s_sel); end
        #2 rst = 1'b1;
        #1;
        n_tests += 7;
        if (s_sel !== 2'b00) begin n_fail++; $display("FAIL midrst_sel got %b want 00", s_sel); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rspv got %b want 0", rsp_valid); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err got %b want 0", rsp_err); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h want 0", rsp_rdata); end
        if (s_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b want 0", s_we); end
        if (s_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", s_addr); end
        if (s_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_wdata got %h want 0", s_wdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests += 2;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_rspv i=%0d got %b want 0", i, rsp_valid); end
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL postrst_ready i=%0d got %b want 1", i, req_ready); end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        clk = 1'b0; rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        s_ack = 2'b00; s_rdata = 64'h0;
        test_reset();
        test_read_slave0();
        test_write_slave1();
        test_unmapped();
        test_timeout();
        test_stray_and_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
